// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (IF) and data (DM) requesters.
// Data side wins ties except after MAX_DM_STREAK back-to-back DM wins while IF was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 3,
  parameter int TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_dm;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [SW-1:0]     r_streak;
  logic [TW-1:0]     r_tcnt;
  logic              r_err;

  logic              w_any_req;
  logic              w_grant_dm;
  logic              w_streak_full;
  logic              w_tmo;

  assign w_any_req     = if_req | dm_req;
  assign w_streak_full = (r_streak == SW'(MAX_DM_STREAK));
  // IF only wins a tie once the DM streak has hit its limit
  assign w_grant_dm    = dm_req & (~if_req | ~w_streak_full);
  assign w_tmo         = (r_tcnt == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_next = BUSY;
      BUSY:    if (mem_ack || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    if_ready = 1'b0;
    dm_ready = 1'b0;
    bus_err  = 1'b0;
    if (r_state == RESP) begin
      if_ready = ~r_owner_dm;
      dm_ready = r_owner_dm;
      bus_err  = r_err;
    end
  end

  assign if_stall  = if_req & ~if_ready;
  assign dm_stall  = dm_req & ~dm_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  // Grant latch, memory handshake, timeout and read-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner_dm  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_streak    <= '0;
      r_tcnt      <= '0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner_dm  <= w_grant_dm;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_grant_dm & dm_we;
            r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
            r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
            if (w_grant_dm && if_req) begin
              r_streak <= w_streak_full ? r_streak : r_streak + SW'(1);
            end else begin
              r_streak <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_owner_dm) r_dm_rdata <= mem_rdata;
            else            r_if_rdata <= mem_rdata;
          end else if (w_tmo) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_owner_dm) r_dm_rdata <= '0;
            else            r_if_rdata <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        RESP: begin
          r_tcnt <= '0;
          r_err  <= 1'b0;
        end
        default: begin
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: a bench-side memory responder acks after a programmable delay,
// expected completions are queued at issue time and popped when a ready pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  logic        auto_ack = 1'b0;
  logic        inj_ack  = 1'b0;
  logic        ack_en   = 1'b1;
  int          ack_delay = 0;
  int          resp_cnt  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          dm;
    logic [31:0] data;
    bit          err;
    bit          chk;
  } exp_t;
  exp_t exp_q[$];

  assign mem_ack = auto_ack | inj_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(3), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h2010FFFF;
  endfunction

  // Memory model: acks the ack_delay-th BUSY cycle (0 = first) when enabled
  always @(negedge clk) begin
    mem_rdata = rd_model(mem_addr);
    if (!mem_req) begin
      resp_cnt = 0;
      auto_ack = 1'b0;
    end else begin
      auto_ack = ack_en && (resp_cnt == ack_delay);
      resp_cnt++;
    end
  end

  task automatic wait_ready(input int max_cyc, output int cyc, output bit expired);
    cyc = 0;
    expired = 1'b0;
    while (!(if_ready || dm_ready)) begin
      @(negedge clk);
      cyc++;
      if (cyc > max_cyc) begin
        expired = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, if_ready, dm_ready, bus_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_we, if_ready, dm_ready, bus_err});
    end
    n_tests++;
    if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h required 0", if_rdata, dm_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_ifetch;
    exp_t e;
    ack_en = 1'b1; ack_delay = 1;
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    exp_q.push_back('{dm: 1'b0, data: rd_model(32'h0), err: 1'b0, chk: 1'b1});
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, if_stall, if_ready} !== 4'b1010 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_c1: got req/we/stall/rdy %b addr %h required 1010 addr 0",
               {mem_req, mem_we, if_stall, if_ready}, mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if ({mem_req, if_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_c2: got req/rdy %b required 10", {mem_req, if_ready});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if ({mem_req, if_ready, dm_ready, bus_err} !== 4'b0100 || if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL fetch_c3: got req/ird/drd/err %b rdata %h required 0100 rdata %h",
               {mem_req, if_ready, dm_ready, bus_err}, if_rdata, e.data);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({if_ready, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_c4: got rdy/req %b required 00", {if_ready, mem_req});
    end
  endtask

  task automatic test_arbitration;
    exp_t e;
    int   cyc;
    bit   expired;
    ack_en = 1'b1; ack_delay = 0;
    if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e.dm   = ((i % 4) != 3);
      e.data = e.dm ? rd_model(32'h200) : rd_model(32'h100);
      e.err  = 1'b0;
      e.chk  = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      wait_ready(10, cyc, expired);
      n_tests++;
      if (expired || cyc != 2) begin
        n_fail++;
        $display("FAIL arb_latency[%0d]: got %0d cycles (expired %0d) required 2", i, cyc, expired);
        break;
      end
      e = exp_q.pop_front();
      n_tests++;
      if ({dm_ready, if_ready} !== {e.dm, ~e.dm} || bus_err !== 1'b0 ||
          (e.dm ? dm_rdata : if_rdata) !== e.data) begin
        n_fail++;
        $display("FAIL arb_grant[%0d]: got dm/if %b%b err %b data %h required %b%b err 0 data %h",
                 i, dm_ready, if_ready, bus_err, e.dm ? dm_rdata : if_rdata, e.dm, ~e.dm, e.data);
      end
      if (i == 7) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic test_store;
    exp_t e;
    ack_en = 1'b1; ack_delay = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    exp_q.push_back('{dm: 1'b1, data: 32'h0, err: 1'b0, chk: 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_req, mem_we, dm_ready} !== 3'b110 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL store_busy[%0d]: got req/we/rdy %b addr %h wdata %h required 110 40 deadbeef",
                 k, {mem_req, mem_we, dm_ready}, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if ({dm_ready, if_ready, bus_err} !== {e.dm, 1'b0, e.err} || if_rdata !== rd_model(32'h100)) begin
      n_fail++;
      $display("FAIL store_done: got dm/if/err %b if_rdata %h required 100 if_rdata %h",
               {dm_ready, if_ready, bus_err}, if_rdata, rd_model(32'h100));
    end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL store_pulse: got dm_ready %b required 0", dm_ready);
    end
  endtask

  task automatic run_dm_load(input logic [31:0] addr, input bit ack_on, input int dly,
                             output int busy, output bit expired);
    ack_en = ack_on; ack_delay = dly;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = addr;
    busy = 0; expired = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) busy++;
      if (dm_ready || if_ready) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    int   busy;
    bit   expired;
    exp_q.push_back('{dm: 1'b1, data: 32'h0, err: 1'b1, chk: 1'b1});
    run_dm_load(32'h80, 1'b0, 0, busy, expired);
    e = exp_q.pop_front();
    n_tests++;
    if (expired || busy != 15) begin
      n_fail++;
      $display("FAIL tmo_len: got %0d busy cycles (expired %0d) required 15", busy, expired);
    end
    n_tests++;
    if ({dm_ready, if_ready, bus_err} !== {e.dm, 1'b0, e.err} || dm_rdata !== e.data) begin
      n_fail++;
      $display("FAIL tmo_resp: got dm/if/err %b dm_rdata %h required 101 dm_rdata %h",
               {dm_ready, if_ready, bus_err}, dm_rdata, e.data);
    end
    dm_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus_err, dm_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL tmo_clear: got err/rdy %b required 00", {bus_err, dm_ready});
    end
    // Ack lands on the very cycle the timeout would fire
    exp_q.push_back('{dm: 1'b1, data: rd_model(32'h84), err: 1'b0, chk: 1'b1});
    run_dm_load(32'h84, 1'b1, 14, busy, expired);
    e = exp_q.pop_front();
    n_tests++;
    if (expired || busy != 15 || {dm_ready, bus_err} !== {e.dm, e.err} || dm_rdata !== e.data) begin
      n_fail++;
      $display("FAIL tmo_edge_ack: got busy %0d rdy/err %b data %h required 15 10 data %h",
               busy, {dm_ready, bus_err}, dm_rdata, e.data);
    end
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    ack_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, if_ready, dm_ready, bus_err} !== 5'b0 ||
        {if_rdata, dm_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL midrst_zero: got ctrl %b data %h %h %h %h required all 0",
               {mem_req, mem_we, if_ready, dm_ready, bus_err}, if_rdata, dm_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    inj_ack = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inj_ack = 1'b0;
      if (mem_req || if_ready || dm_ready || bus_err || if_rdata !== 32'h0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrst_late_ack: got %0d active cycles required 0", seen);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_drop;
    exp_t e;
    int   cyc;
    int   seen;
    bit   expired;
    ack_en = 1'b1; ack_delay = 2;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    exp_q.push_back('{dm: 1'b1, data: rd_model(32'h500), err: 1'b0, chk: 1'b1});
    @(negedge clk);
    n_tests++;
    if ({dm_stall, mem_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL drop_busy: got stall/req %b required 11", {dm_stall, mem_req});
    end
    dm_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dm_stall, mem_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_hold: got stall/req %b required 01", {dm_stall, mem_req});
    end
    wait_ready(10, cyc, expired);
    e = exp_q.pop_front();
    n_tests++;
    if (expired || {dm_ready, if_ready, bus_err} !== {e.dm, 1'b0, e.err} || dm_rdata !== e.data) begin
      n_fail++;
      $display("FAIL drop_done: got dm/if/err %b data %h (expired %0d) required 100 data %h",
               {dm_ready, if_ready, bus_err}, dm_rdata, expired, e.data);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req || dm_ready || if_ready) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL drop_no_regrant: got %0d active cycles required 0", seen);
    end
    dm_req = 1'b1; dm_addr = 32'h504;
    @(negedge clk);
    dm_req = 1'b0;
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h504}) begin
      n_fail++;
      $display("FAIL drop_fresh: got req %b addr %h required 1 504", mem_req, mem_addr);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_arbitration();
    test_store();
    test_timeout();
    test_reset_mid();
    test_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
